// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding,
// beat counter width and a small id-width helper.
package fifo_wr_arb_pkg;

    // Arbiter FSM states. IDLE arbitrates, BURST streams the owner's beats.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Width of the per-burst beat counter. The counter holds 0..MAX_BURST-1,
    // so MAX_BURST up to 256 fits without overflow.
    localparam int CNT_W = 8;

    // Index width for n requesters. Never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fifo_wr_arb_pkg

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker. The search starts one slot after the
// previous owner and wraps modulo N; the first asserted request wins.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req_vec_i,
    input  logic [id_width(N)-1:0] last_owner_i,
    output logic [id_width(N)-1:0] winner_o,
    output logic                   any_o
);

    localparam int IDW = id_width(N);

    // Walk the offsets from farthest to nearest so the nearest valid
    // requester after last_owner_i is the final (winning) assignment.
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_owner_i) + k) % N;
            if (req_vec_i[idx[IDW-1:0]]) begin
                winner_o = idx[IDW-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that funnels bursts from NUM_REQ requesters into the
// write port of a single synchronous FIFO. One requester owns the port for a
// whole burst; a burst ends on its last-marked beat or after MAX_BURST beats.
//
// Handshake: a beat moves on a rising clk edge where valid and ready are both
// high. During BURST the owner's valid/data pass straight through to
// wr_valid/wr_din, and the FIFO's wr_ready passes straight back to the owner's
// req_ready; every other requester sees ready low and keeps its beat.
//
// The FSM has two states and busy is the state register itself, so busy is
// the observable state for checkers (busy=0 IDLE, busy=1 BURST).
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_valid,
    output logic [DATA_WIDTH-1:0]         wr_din,
    input  logic                          wr_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);

    // Counter value seen on the beat that completes a maximum-length burst.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    // After reset the previous owner is the highest index, so requester 0
    // is searched first.
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDW-1:0]        pick_id;
    logic                  pick_any;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  xfer;
    logic                  burst_end;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req_vec_i    (req_valid),
        .last_owner_i (last_q),
        .winner_o     (pick_id),
        .any_o        (pick_any)
    );

    // Select the current owner's valid, last marker and data beat.
    always_comb begin
        owner_valid = req_valid[grant_q];
        owner_last  = req_last[grant_q];
        owner_data  = req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    end

    // A beat moves only while bursting and both sides agree; the burst closes
    // on the last-marked beat or on the beat that completes MAX_BURST.
    always_comb begin
        xfer      = (state_q == BURST) && owner_valid && wr_ready;
        burst_end = xfer && (owner_last || (cnt_q == LAST_CNT));
    end

    // FSM state, owner, previous owner and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and close in BURST.
    // An owner that drops valid or a full FIFO simply holds everything.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_id;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (burst_end) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux: pass the owner's beat through while bursting, nothing in IDLE.
    always_comb begin
        wr_valid  = 1'b0;
        wr_din    = '0;
        req_ready = '0;
        if (state_q == BURST) begin
            wr_valid           = owner_valid;
            wr_din             = owner_data;
            req_ready[grant_q] = wr_ready;
        end
    end

    assign busy     = (state_q == BURST);
    assign grant_id = grant_q;

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb. Each requester replays a stream of
// beats from a table; a transaction-level model predicts whole bursts at grant
// time and queues the expected (owner, data) beats, and a separate monitor
// pops and compares every beat the DUT writes toward the FIFO.
module tb_fifo_wr_arb;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 16;
    localparam int IDW       = $clog2(NUM_REQ);
    localparam int DEPTH     = 256;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    wr_valid;
    logic [DW-1:0]           wr_din;
    logic                    wr_ready;
    logic [IDW-1:0]          grant_id;
    logic                    busy;

    fifo_wr_arb #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_valid  (wr_valid),
        .wr_din    (wr_din),
        .wr_ready  (wr_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int tests;
    int fails;

    logic [IDW+DW-1:0] exp_q[$];

    logic [DW-1:0] src_data [NUM_REQ][DEPTH];
    logic          src_last [NUM_REQ][DEPTH];
    int            src_len  [NUM_REQ];
    int            ptr      [NUM_REQ];

    logic [NUM_REQ-1:0] en;
    logic               wr_rdy;
    bit                 rand_mode;

    // Transaction-level model of the arbiter.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_left;

    // Observed burst history taken from the DUT pins.
    bit busy_prev;
    int burst_beats;
    int grant_log[$];
    int len_log[$];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_model(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    function automatic bit all_drained();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ptr[i] != src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // last_mode: 0 = never last, 1 = last on final beat, 2 = random lasts plus final
    task automatic load(input int i, input int n, input int last_mode);
        for (int p = 0; p < n; p++) begin
            src_data[i][p] = DW'($urandom);
            case (last_mode)
                0:       src_last[i][p] = 1'b0;
                1:       src_last[i][p] = (p == n - 1);
                default: src_last[i][p] = (p == n - 1) || ($urandom_range(0, 5) == 0);
            endcase
        end
        src_len[i] = n;
        ptr[i]     = 0;
    endtask

    task automatic clear_streams();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0;
            ptr[i]     = 0;
        end
    endtask

    // Driver: present each requester's current beat.
    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]          = en[i] && (ptr[i] < src_len[i]);
            req_data[i*DW +: DW]  = src_data[i][ptr[i]];
            req_last[i]           = src_last[i][ptr[i]];
        end
        wr_ready = wr_rdy;
    endtask

    // Model: a grant queues the whole burst it will deliver.
    task automatic push_burst(input int o);
        int n;
        bit ended;
        n     = 0;
        ended = 1'b0;
        for (int p = ptr[o]; p < src_len[o] && n < MAX_BURST; p++) begin
            exp_q.push_back({IDW'(o), src_data[o][p]});
            n++;
            if (src_last[o][p]) begin
                ended = 1'b1;
                break;
            end
        end
        m_left = (ended || n == MAX_BURST) ? n : MAX_BURST;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (req_valid != '0) begin
                m_owner = rr_model(m_last, req_valid);
                push_burst(m_owner);
                m_busy = 1'b1;
            end
        end else if (req_valid[m_owner] && wr_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        m_busy    = 1'b0;
        m_last    = NUM_REQ - 1;
        m_owner   = 0;
        m_left    = 0;
        busy_prev = 1'b0;
        burst_beats = 0;
        exp_q.delete();
        grant_log.delete();
        len_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive, check pins against the model on the falling edge,
    // advance the model, then retire accepted beats after the rising edge.
    task automatic cycle();
        logic [NUM_REQ-1:0] hs;
        logic [NUM_REQ-1:0] exp_rdy;
        drive();
        @(negedge clk);
        check("busy", 32'(busy), 32'(m_busy));
        if (m_busy) check("grant_id", 32'(grant_id), 32'(m_owner));
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_owner] = wr_ready;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("wr_valid", 32'(wr_valid), 32'(m_busy && req_valid[m_owner]));
        if (busy && !busy_prev) begin
            grant_log.push_back(int'(grant_id));
            burst_beats = 0;
        end
        if (busy && wr_valid && wr_ready) burst_beats++;
        if (!busy && busy_prev) len_log.push_back(burst_beats);
        busy_prev = busy;
        hs = req_valid & req_ready;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) ptr[i]++;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (!(all_drained() && !m_busy && exp_q.size() == 0) && n < budget) begin
            if (rand_mode) begin
                for (int i = 0; i < NUM_REQ; i++) en[i] = ($urandom_range(0, 4) != 0);
                wr_rdy = ($urandom_range(0, 3) != 0);
            end
            cycle();
            n++;
        end
        check({name, "_finished_in_budget"}, 32'(n < budget), 32'd1);
        check({name, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic int log_at(input int which, input int k);
        if (which == 0) return (k < grant_log.size()) ? grant_log[k] : -1;
        return (k < len_log.size()) ? len_log[k] : -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [IDW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got id=%0d data=0x%0h, expected no beat (t=%0t)",
                             grant_id, wr_din, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'({grant_id, wr_din}), 32'(e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int exp_order[5];
        tests     = 0;
        fails     = 0;
        rand_mode = 1'b0;
        en        = '0;
        wr_rdy    = 1'b1;
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = NUM_REQ - 1;
        busy_prev = 1'b0;
        burst_beats = 0;
        clear_streams();
        drive();

        // Reset state, observed while reset is held.
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        do_reset();

        // Single requester: three beats A1, A2, A3 with last on the third.
        src_data[0][0] = 8'hA1; src_last[0][0] = 1'b0;
        src_data[0][1] = 8'hA2; src_last[0][1] = 1'b0;
        src_data[0][2] = 8'hA3; src_last[0][2] = 1'b1;
        src_len[0] = 3;
        ptr[0]     = 0;
        en         = 4'b0001;
        wr_rdy     = 1'b1;
        cycle();
        check("t1_busy_after_arb", 32'(busy), 32'd1);
        check("t1_grant_after_arb", 32'(grant_id), 32'd0);
        drain(20, "t1");
        check("t1_busy_after_burst", 32'(busy), 32'd0);
        cycle();
        check("t1_burst_len", 32'(log_at(1, 0)), 32'd3);

        // Fairness: everyone always valid, no last -> 16-beat bursts 0,1,2,3,0.
        do_reset();
        clear_streams();
        for (int i = 0; i < NUM_REQ; i++) load(i, 100, 0);
        en = '1;
        wr_rdy = 1'b1;
        n = 0;
        while (grant_log.size() < 5 && n < 150) begin
            cycle();
            n++;
        end
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) check("t2_grant_order", 32'(log_at(0, k)), 32'(exp_order[k]));
        for (int k = 0; k < 4; k++) check("t2_burst_len", 32'(log_at(1, k)), 32'(MAX_BURST));

        // Backpressure: req2 sends 4 beats while wr_ready alternates.
        do_reset();
        clear_streams();
        load(2, 4, 1);
        en = 4'b0100;
        n = 0;
        while (!(all_drained() && !m_busy) && n < 30) begin
            wr_rdy = (n % 2 == 0);
            cycle();
            n++;
        end
        wr_rdy = 1'b1;
        drain(10, "t3");
        cycle();
        check("t3_burst_len", 32'(log_at(1, 0)), 32'd4);
        check("t3_beats_consumed", 32'(ptr[2]), 32'd4);

        // Owner stall: req1 drops valid for 5 cycles while req3 waits.
        do_reset();
        clear_streams();
        load(1, 8, 1);
        load(3, 4, 1);
        en = 4'b1010;
        n = 0;
        while (ptr[1] < 3 && n < 20) begin
            cycle();
            n++;
        end
        en[1] = 1'b0;
        repeat (5) begin
            cycle();
            check("t4_grant_held", 32'(grant_id), 32'd1);
            check("t4_req3_not_ready", 32'(req_ready[3]), 32'd0);
        end
        en[1] = 1'b1;
        drain(40, "t4");
        cycle();
        check("t4_first_grant", 32'(log_at(0, 0)), 32'd1);
        check("t4_second_grant", 32'(log_at(0, 1)), 32'd3);

        // Reset in the middle of req3's burst, then req0 and req3 compete.
        do_reset();
        clear_streams();
        load(3, 6, 1);
        en = 4'b1000;
        n = 0;
        while (ptr[3] < 2 && n < 20) begin
            cycle();
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("t5_busy_in_rst", 32'(busy), 32'd0);
        check("t5_wr_valid_in_rst", 32'(wr_valid), 32'd0);
        check("t5_req_ready_in_rst", 32'(req_ready), 32'd0);
        check("t5_grant_in_rst", 32'(grant_id), 32'd0);
        load(0, 3, 1);
        en = 4'b1001;
        do_reset();
        drain(60, "t5");
        cycle();
        check("t5_first_grant", 32'(log_at(0, 0)), 32'd0);
        check("t5_second_grant", 32'(log_at(0, 1)), 32'd3);
        check("t5_req3_beats", 32'(ptr[3]), 32'd6);

        // Randomized traffic: random lengths, lasts, valid gaps and backpressure.
        do_reset();
        clear_streams();
        rand_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) load(i, $urandom_range(1, 40), 2);
            drain(2000, "rand");
        end
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_wr_arb

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, beat width.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, maximum beats per grant (1..256).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port req_valid, input, NUM_REQ: per-requester beat valid.
REQ-008 Port req_data, input, NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_last, input, NUM_REQ: per-requester end-of-burst marker.
REQ-010 Port req_ready, output, NUM_REQ: per-requester beat accept.
REQ-011 Port wr_valid, output, 1: beat valid toward the sync FIFO write port.
REQ-012 Port wr_din, output, DATA_WIDTH: beat data toward the FIFO.
REQ-013 Port wr_ready, input, 1: FIFO not full.
REQ-014 Port grant_id, output, clog2(NUM_REQ): index of the current owner.
REQ-015 Port busy, output, 1: a burst is in progress.

Function
REQ-016 A beat SHALL transfer on a rising edge where both valid and ready are high.
REQ-017 The FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with any req_valid high, the FSM SHALL latch the round-robin winner into grant_id and enter BURST next cycle, giving one cycle of arbitration latency.
REQ-019 In IDLE with all req_valid low, the FSM SHALL remain in IDLE.
REQ-020 Round-robin search SHALL start at last_owner+1 modulo NUM_REQ and pick the first requester with valid high.
REQ-021 In BURST, wr_valid SHALL equal req_valid[grant_id] and wr_din SHALL equal req_data[grant_id], combinationally.
REQ-022 In BURST, req_ready[grant_id] SHALL equal wr_ready and every other req_ready bit SHALL be 0.
REQ-023 In IDLE, wr_valid SHALL be 0 and req_ready SHALL be all 0.
REQ-024 The 8-bit beat counter SHALL clear on entry to BURST and increment on each transfer.
REQ-025 The burst SHALL end on the transfer with req_last high, or on the transfer that makes the count reach MAX_BURST, whichever comes first.
REQ-026 At burst end, last_owner SHALL be set to grant_id and the FSM SHALL return to IDLE, giving one idle bubble between bursts.
REQ-027 If the owner drops req_valid mid-burst, the grant SHALL be held with no timeout.
REQ-028 If wr_ready is low (FIFO full), the FSM SHALL hold state and the counter SHALL hold.
REQ-029 A requester that loses arbitration SHALL see req_ready=0 and SHALL NOT lose data.
REQ-030 busy SHALL be 1 exactly when the state is BURST.
REQ-031 Changes to req_valid of non-owners during BURST SHALL have no effect.

Reset
REQ-032 Asserting rst SHALL immediately force: state IDLE, grant_id 0, last_owner NUM_REQ-1 (requester 0 has first priority), counter 0, busy 0, wr_valid 0, req_ready 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no further transfer; the first arbitration after release SHALL follow REQ-032 priority.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=0, BURST=1) and the counter width constant (8).
REQ-035 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs: request vector, last_owner; outputs: winner index, any).
REQ-036 The FSM, counter and output mux SHALL be in fifo_wr_arb, and rr_pick SHALL be its only sub-module.

Verification
REQ-037 Single-requester test: req0 sends 3 beats 0xA1,0xA2,0xA3 with last on the third and wr_ready=1 -> grant_id=0, one IDLE cycle, then 3 consecutive wr_din beats, then busy=0.
REQ-038 Fairness test: all 4 requesters continuously valid with no last -> grants in order 0,1,2,3,0, each burst exactly 16 beats.
REQ-039 Backpressure test: wr_ready toggles 1,0,1,0 during req2's 4-beat burst -> 4 beats delivered in order, counter holds while wr_ready=0, no duplicate or lost beats.
REQ-040 Owner-stall test: req1 drops valid for 5 cycles mid-burst while req3 is valid -> grant_id stays 1 and req_ready[3]=0 throughout.
REQ-041 Reset-mid-burst test: rst pulsed after 2 beats of req3's burst -> outputs 0 immediately; after release with req0 and req3 both valid, req0 is granted first.
